// File: rtl/culsans_pkg.sv
// -----------------------------------------------------------------------------
// culsans_pkg
// Shared definitions for the Culsans AXI ID remapper.
//   - Default upstream/downstream ID widths (downstream derived from the
//     upstream width) and the default per-slot transaction limit.
//   - remap_slot_t: layout of one remap table entry {in_id, count} at the
//     default widths.
//   - cnt_width(): width of a per-slot counter able to hold 0..max_txn.
// Optional feature macro used by culsans_id_remap: CULSANS_ID_REMAP_STAT_EN.
// -----------------------------------------------------------------------------
package culsans_pkg;

    localparam int unsigned IdWidthSlave      = 8;
    localparam int unsigned IdWidthMaster     = IdWidthSlave / 2;
    localparam int unsigned MaxTxnPerId       = 4;
    localparam int unsigned RemapCntWidth     = $clog2(MaxTxnPerId + 1);
    localparam int unsigned UnmappedCntWidth  = 16;

    // One remap table entry: the upstream ID that owns the slot and the number
    // of transactions still outstanding on it. count == 0 means the slot is free.
    typedef struct packed {
        logic [IdWidthSlave-1:0]  in_id;
        logic [RemapCntWidth-1:0] count;
    } remap_slot_t;

    function automatic int unsigned cnt_width(input int unsigned max_txn);
        return $clog2(max_txn + 1);
    endfunction

endpackage

// File: rtl/culsans_id_remap_table.sv
// -----------------------------------------------------------------------------
// culsans_id_remap_table
// Remap slot table: one entry per downstream ID holding the owning upstream ID
// and an outstanding-transaction counter.
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   lookup_id_i            upstream ID of the request currently presented
//   grant_ok_o             the request may be accepted (hit below limit, or a
//                          free slot exists for an unmapped ID)
//   grant_idx_o            slot the request maps to
//   alloc_i                request handshake: allocate/increment grant_idx_o
//   rsp_idx_i              downstream ID of the current response beat
//   rsp_last_fire_i        handshaked last beat on rsp_idx_i
//   rsp_in_id_o            stored upstream ID of slot rsp_idx_i
//   rsp_mapped_o           slot rsp_idx_i is allocated
//   any_alloc_o            at least one slot is allocated
// -----------------------------------------------------------------------------
module culsans_id_remap_table
    import culsans_pkg::*;
#(
    parameter int unsigned IN_ID_WIDTH    = IdWidthSlave,
    parameter int unsigned OUT_ID_WIDTH   = IdWidthMaster,
    parameter int unsigned MAX_TXN_PER_ID = MaxTxnPerId
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [IN_ID_WIDTH-1:0]  lookup_id_i,
    output logic                    grant_ok_o,
    output logic [OUT_ID_WIDTH-1:0] grant_idx_o,
    input  logic                    alloc_i,
    input  logic [OUT_ID_WIDTH-1:0] rsp_idx_i,
    input  logic                    rsp_last_fire_i,
    output logic [IN_ID_WIDTH-1:0]  rsp_in_id_o,
    output logic                    rsp_mapped_o,
    output logic                    any_alloc_o
);

    localparam int unsigned NUM_SLOTS = 1 << OUT_ID_WIDTH;
    localparam int unsigned CNT_W     = cnt_width(MAX_TXN_PER_ID);

    // Same layout as remap_slot_t, resized to this instance's parameters.
    typedef struct packed {
        logic [IN_ID_WIDTH-1:0] in_id;
        logic [CNT_W-1:0]       count;
    } slot_t;

    logic [NUM_SLOTS-1:0][IN_ID_WIDTH-1:0] slot_in_id;
    logic [NUM_SLOTS-1:0][CNT_W-1:0]       slot_cnt;
    logic [NUM_SLOTS-1:0]                  slot_used;
    logic [NUM_SLOTS-1:0]                  slot_match;

    logic                    hit;
    logic [OUT_ID_WIDTH-1:0] hit_idx;
    logic                    free_found;
    logic [OUT_ID_WIDTH-1:0] free_idx;

    // ------------------------------------------------------------------
    // Per-slot storage and counter update
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : gen_slot
        slot_t slot_q;
        slot_t slot_d;
        logic  inc;
        logic  dec;

        assign slot_used[gi]  = (slot_q.count != '0);
        assign slot_match[gi] = slot_used[gi] && (slot_q.in_id == lookup_id_i);
        assign slot_in_id[gi] = slot_q.in_id;
        assign slot_cnt[gi]   = slot_q.count;

        assign inc = alloc_i && grant_ok_o && (grant_idx_o == OUT_ID_WIDTH'(gi));
        // Last beats on a free slot are ignored so the counter never underflows.
        assign dec = rsp_last_fire_i && slot_used[gi] && (rsp_idx_i == OUT_ID_WIDTH'(gi));

        // Simultaneous increment and decrement cancel out; the slot stays
        // allocated even when its count was 1.
        always_comb begin
            slot_d = slot_q;
            if (inc && !dec) begin
                slot_d.in_id = lookup_id_i;
                slot_d.count = slot_q.count + CNT_W'(1);
            end else if (dec && !inc) begin
                slot_d.count = slot_q.count - CNT_W'(1);
            end
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                slot_q <= '0;
            end else begin
                slot_q <= slot_d;
            end
        end
    end

    // ------------------------------------------------------------------
    // Lookup: existing mapping first, else lowest-index free slot
    // ------------------------------------------------------------------
    always_comb begin
        hit        = 1'b0;
        hit_idx    = '0;
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (slot_match[i] && !hit) begin
                hit     = 1'b1;
                hit_idx = OUT_ID_WIDTH'(i);
            end
            if (!slot_used[i] && !free_found) begin
                free_found = 1'b1;
                free_idx   = OUT_ID_WIDTH'(i);
            end
        end
    end

    always_comb begin
        grant_ok_o  = 1'b0;
        grant_idx_o = '0;
        if (hit) begin
            // Reusing the slot keeps same-ID ordering downstream.
            grant_ok_o  = (slot_cnt[hit_idx] < CNT_W'(MAX_TXN_PER_ID));
            grant_idx_o = hit_idx;
        end else begin
            grant_ok_o  = free_found;
            grant_idx_o = free_idx;
        end
    end

    assign rsp_in_id_o  = slot_in_id[rsp_idx_i];
    assign rsp_mapped_o = slot_used[rsp_idx_i];
    assign any_alloc_o  = |slot_used;

endmodule

// File: rtl/culsans_id_remap.sv
// -----------------------------------------------------------------------------
// culsans_id_remap
// Compresses wide upstream AXI IDs onto 2**OUT_ID_WIDTH downstream IDs.
// Requests pass through a single output register (1-cycle latency); responses
// pass through combinationally with the original ID restored from the table.
// Ports:
//   clk_i, rst_ni                       clock, asynchronous active-low reset
//   slv_req_{valid,ready,id,pld}        upstream request channel
//   mst_req_{valid,ready,id,pld}        downstream request channel (remapped ID)
//   mst_rsp_{valid,ready,id,last,pld}   downstream response channel
//   slv_rsp_{valid,ready,id,last,pld}   upstream response channel (restored ID)
//   busy_o                              slot allocated or request register full
//   unmapped_rsp_o, unmapped_cnt_o      only with CULSANS_ID_REMAP_STAT_EN:
//                                       sticky flag / saturating count of last
//                                       beats arriving on a free slot
// Optional feature macro: CULSANS_ID_REMAP_STAT_EN
// -----------------------------------------------------------------------------
module culsans_id_remap
    import culsans_pkg::*;
#(
    parameter int unsigned IN_ID_WIDTH    = IdWidthSlave,
    parameter int unsigned OUT_ID_WIDTH   = IdWidthMaster,
    parameter int unsigned MAX_TXN_PER_ID = MaxTxnPerId,
    parameter int unsigned REQ_PLD_WIDTH  = 64,
    parameter int unsigned RSP_PLD_WIDTH  = 64
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     slv_req_valid_i,
    output logic                     slv_req_ready_o,
    input  logic [IN_ID_WIDTH-1:0]   slv_req_id_i,
    input  logic [REQ_PLD_WIDTH-1:0] slv_req_pld_i,
    output logic                     mst_req_valid_o,
    input  logic                     mst_req_ready_i,
    output logic [OUT_ID_WIDTH-1:0]  mst_req_id_o,
    output logic [REQ_PLD_WIDTH-1:0] mst_req_pld_o,
    input  logic                     mst_rsp_valid_i,
    output logic                     mst_rsp_ready_o,
    input  logic [OUT_ID_WIDTH-1:0]  mst_rsp_id_i,
    input  logic                     mst_rsp_last_i,
    input  logic [RSP_PLD_WIDTH-1:0] mst_rsp_pld_i,
    output logic                     slv_rsp_valid_o,
    input  logic                     slv_rsp_ready_i,
    output logic [IN_ID_WIDTH-1:0]   slv_rsp_id_o,
    output logic                     slv_rsp_last_o,
    output logic [RSP_PLD_WIDTH-1:0] slv_rsp_pld_o,
    output logic                     busy_o
`ifdef CULSANS_ID_REMAP_STAT_EN
    ,
    output logic                        unmapped_rsp_o,
    output logic [UnmappedCntWidth-1:0] unmapped_cnt_o
`endif
);

    logic                    grant_ok;
    logic [OUT_ID_WIDTH-1:0] grant_idx;
    logic                    req_fire;
    logic                    reg_free;
    logic                    rsp_last_fire;
    logic [IN_ID_WIDTH-1:0]  rsp_raw_in_id;
    logic                    rsp_mapped;
    logic                    any_alloc;

    logic                     out_valid_q, out_valid_d;
    logic [OUT_ID_WIDTH-1:0]  out_id_q,    out_id_d;
    logic [REQ_PLD_WIDTH-1:0] out_pld_q,   out_pld_d;

    culsans_id_remap_table #(
        .IN_ID_WIDTH    (IN_ID_WIDTH),
        .OUT_ID_WIDTH   (OUT_ID_WIDTH),
        .MAX_TXN_PER_ID (MAX_TXN_PER_ID)
    ) u_table (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .lookup_id_i     (slv_req_id_i),
        .grant_ok_o      (grant_ok),
        .grant_idx_o     (grant_idx),
        .alloc_i         (req_fire),
        .rsp_idx_i       (mst_rsp_id_i),
        .rsp_last_fire_i (rsp_last_fire),
        .rsp_in_id_o     (rsp_raw_in_id),
        .rsp_mapped_o    (rsp_mapped),
        .any_alloc_o     (any_alloc)
    );

    // ------------------------------------------------------------------
    // Request path: single output register, refillable while draining
    // ------------------------------------------------------------------
    assign reg_free        = !out_valid_q || mst_req_ready_i;
    assign slv_req_ready_o = reg_free && grant_ok;
    assign req_fire        = slv_req_valid_i && slv_req_ready_o;

    always_comb begin
        out_valid_d = out_valid_q;
        out_id_d    = out_id_q;
        out_pld_d   = out_pld_q;
        if (req_fire) begin
            out_valid_d = 1'b1;
            out_id_d    = grant_idx;
            out_pld_d   = slv_req_pld_i;
        end else if (mst_req_ready_i) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_valid_q <= 1'b0;
            out_id_q    <= '0;
            out_pld_q   <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_id_q    <= out_id_d;
            out_pld_q   <= out_pld_d;
        end
    end

    assign mst_req_valid_o = out_valid_q;
    assign mst_req_id_o    = out_id_q;
    assign mst_req_pld_o   = out_pld_q;

    // ------------------------------------------------------------------
    // Response path: combinational pass-through with ID restore.
    // A beat on a free slot goes up with ID 0.
    // ------------------------------------------------------------------
    assign slv_rsp_valid_o = mst_rsp_valid_i;
    assign mst_rsp_ready_o = slv_rsp_ready_i;
    assign slv_rsp_last_o  = mst_rsp_last_i;
    assign slv_rsp_pld_o   = mst_rsp_pld_i;
    assign slv_rsp_id_o    = rsp_mapped ? rsp_raw_in_id : '0;
    assign rsp_last_fire   = mst_rsp_valid_i && slv_rsp_ready_i && mst_rsp_last_i;

    assign busy_o = any_alloc || out_valid_q;

`ifdef CULSANS_ID_REMAP_STAT_EN
    // ------------------------------------------------------------------
    // Unmapped-response statistics
    // ------------------------------------------------------------------
    logic                        unmapped_hit;
    logic                        unm_sticky_q, unm_sticky_d;
    logic [UnmappedCntWidth-1:0] unm_cnt_q,    unm_cnt_d;

    assign unmapped_hit = rsp_last_fire && !rsp_mapped;

    always_comb begin
        unm_sticky_d = unm_sticky_q;
        unm_cnt_d    = unm_cnt_q;
        if (unmapped_hit) begin
            unm_sticky_d = 1'b1;
            if (unm_cnt_q != '1) begin
                unm_cnt_d = unm_cnt_q + UnmappedCntWidth'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            unm_sticky_q <= 1'b0;
            unm_cnt_q    <= '0;
        end else begin
            unm_sticky_q <= unm_sticky_d;
            unm_cnt_q    <= unm_cnt_d;
        end
    end

    assign unmapped_rsp_o = unm_sticky_q;
    assign unmapped_cnt_o = unm_cnt_q;
`endif

endmodule

// File: tb/tb_culsans_id_remap.sv
// -----------------------------------------------------------------------------
// tb_culsans_id_remap
// Directed scenarios followed by randomized traffic, all checked each cycle
// against a behavioural table model (plain arrays of owner ID and count).
// -----------------------------------------------------------------------------
module tb_culsans_id_remap;

    localparam int NSLOT = 16;
    localparam int MAXT  = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        slv_req_valid;
    logic        slv_req_ready;
    logic [7:0]  slv_req_id;
    logic [63:0] slv_req_pld;
    logic        mst_req_valid;
    logic        mst_req_ready;
    logic [3:0]  mst_req_id;
    logic [63:0] mst_req_pld;
    logic        mst_rsp_valid;
    logic        mst_rsp_ready;
    logic [3:0]  mst_rsp_id;
    logic        mst_rsp_last;
    logic [63:0] mst_rsp_pld;
    logic        slv_rsp_valid;
    logic        slv_rsp_ready;
    logic [7:0]  slv_rsp_id;
    logic        slv_rsp_last;
    logic [63:0] slv_rsp_pld;
    logic        busy;
`ifdef CULSANS_ID_REMAP_STAT_EN
    logic        unmapped_rsp;
    logic [15:0] unmapped_cnt;
`endif

    always #5 clk = ~clk;

    culsans_id_remap dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .slv_req_valid_i (slv_req_valid),
        .slv_req_ready_o (slv_req_ready),
        .slv_req_id_i    (slv_req_id),
        .slv_req_pld_i   (slv_req_pld),
        .mst_req_valid_o (mst_req_valid),
        .mst_req_ready_i (mst_req_ready),
        .mst_req_id_o    (mst_req_id),
        .mst_req_pld_o   (mst_req_pld),
        .mst_rsp_valid_i (mst_rsp_valid),
        .mst_rsp_ready_o (mst_rsp_ready),
        .mst_rsp_id_i    (mst_rsp_id),
        .mst_rsp_last_i  (mst_rsp_last),
        .mst_rsp_pld_i   (mst_rsp_pld),
        .slv_rsp_valid_o (slv_rsp_valid),
        .slv_rsp_ready_i (slv_rsp_ready),
        .slv_rsp_id_o    (slv_rsp_id),
        .slv_rsp_last_o  (slv_rsp_last),
        .slv_rsp_pld_o   (slv_rsp_pld),
        .busy_o          (busy)
`ifdef CULSANS_ID_REMAP_STAT_EN
        ,
        .unmapped_rsp_o  (unmapped_rsp),
        .unmapped_cnt_o  (unmapped_cnt)
`endif
    );

    // ------------------------------------------------------------------
    // Reference model: who owns each downstream ID and how many are open
    // ------------------------------------------------------------------
    int          m_cnt [NSLOT];
    logic [7:0]  m_own [NSLOT];
    bit          m_ov;
    logic [3:0]  m_oid;
    logic [63:0] m_opld;
    int          m_unm_cnt;
    bit          m_unm_flag;

    int checks   = 0;
    int failures = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < NSLOT; i++) begin
            m_cnt[i] = 0;
            m_own[i] = '0;
        end
        m_ov       = 1'b0;
        m_oid      = '0;
        m_opld     = '0;
        m_unm_cnt  = 0;
        m_unm_flag = 1'b0;
    endfunction

    // Which downstream ID a request would use, and whether it may go now.
    function automatic void model_lookup(input logic [7:0] id, output bit ok, output int idx);
        idx = -1;
        ok  = 1'b0;
        for (int i = 0; i < NSLOT; i++)
            if (idx < 0 && m_cnt[i] > 0 && m_own[i] == id) idx = i;
        if (idx >= 0) begin
            ok = (m_cnt[idx] < MAXT);
        end else begin
            for (int i = 0; i < NSLOT; i++)
                if (idx < 0 && m_cnt[i] == 0) idx = i;
            ok = (idx >= 0);
        end
    endfunction

    function automatic bit model_any_busy();
        bit b = m_ov;
        for (int i = 0; i < NSLOT; i++) if (m_cnt[i] > 0) b = 1'b1;
        return b;
    endfunction

    // One clock cycle: drive, check mid-cycle, advance the model.
    task automatic drive_cycle(input bit rv, input logic [7:0] rid, input bit mrdy,
                               input bit pv, input logic [3:0] pid, input bit plast,
                               input bit srdy);
        bit          ok;
        int          idx;
        bit          exp_rdy;
        bit          mapped;
        logic [63:0] rpld;
        logic [63:0] ppld;
        rpld = {$urandom, $urandom};
        ppld = {$urandom, $urandom};
        slv_req_valid = rv;
        slv_req_id    = rid;
        slv_req_pld   = rpld;
        mst_req_ready = mrdy;
        mst_rsp_valid = pv;
        mst_rsp_id    = pid;
        mst_rsp_last  = plast;
        mst_rsp_pld   = ppld;
        slv_rsp_ready = srdy;
        @(negedge clk);

        model_lookup(rid, ok, idx);
        exp_rdy = (!m_ov || mrdy) && ok;
        mapped  = (m_cnt[pid] > 0);

        check_val("mst_req_valid", 64'(mst_req_valid), 64'(m_ov));
        if (m_ov) begin
            check_val("mst_req_id", 64'(mst_req_id), 64'(m_oid));
            check_val("mst_req_pld", mst_req_pld, m_opld);
        end
        check_val("slv_req_ready", 64'(slv_req_ready), 64'(exp_rdy));
        check_val("busy", 64'(busy), 64'(model_any_busy()));
        check_val("slv_rsp_id", 64'(slv_rsp_id), mapped ? 64'(m_own[pid]) : 64'd0);
        check_val("rsp_passthru", {slv_rsp_pld[60:0], slv_rsp_valid, slv_rsp_last, mst_rsp_ready},
                  {ppld[60:0], pv, plast, srdy});
`ifdef CULSANS_ID_REMAP_STAT_EN
        check_val("unmapped_cnt", 64'(unmapped_cnt), 64'(m_unm_cnt));
        check_val("unmapped_rsp", 64'(unmapped_rsp), 64'(m_unm_flag));
`endif

        if (rv && exp_rdy)
            $display("t=%0t req  in_id=%02h -> mst_id=%0d", $time, rid, idx);
        if (pv && srdy)
            $display("t=%0t rsp  mst_id=%0d last=%0b -> in_id=%02h", $time, pid, plast,
                     mapped ? m_own[pid] : 8'h00);

        // Advance model: decrement is computed against the pre-cycle table.
        if (pv && srdy && plast) begin
            if (mapped) begin
                m_cnt[pid]--;
            end else begin
                m_unm_flag = 1'b1;
                if (m_unm_cnt < 65535) m_unm_cnt++;
            end
        end
        if (rv && exp_rdy) begin
            m_cnt[idx]++;
            m_own[idx] = rid;
            m_ov       = 1'b1;
            m_oid      = 4'(idx);
            m_opld     = rpld;
        end else if (mrdy) begin
            m_ov = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        slv_req_valid = 1'b0;
        slv_req_id    = '0;
        slv_req_pld   = '0;
        mst_req_ready = 1'b0;
        mst_rsp_valid = 1'b0;
        mst_rsp_id    = '0;
        mst_rsp_last  = 1'b0;
        mst_rsp_pld   = '0;
        slv_rsp_ready = 1'b0;
    endtask

    // Asynchronous reset: outputs must clear without waiting for a clock.
    task automatic apply_reset(input string tag);
        idle_inputs();
        rst_n = 1'b0;
        #1;
        check_val({tag, "_busy"}, 64'(busy), 64'd0);
        check_val({tag, "_mst_valid"}, 64'(mst_req_valid), 64'd0);
`ifdef CULSANS_ID_REMAP_STAT_EN
        check_val({tag, "_unm_cnt"}, 64'(unmapped_cnt), 64'd0);
`endif
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int          q[$];
        logic [3:0]  pid;
        rst_n = 1'b0;
        idle_inputs();
        model_reset();
        #3;
        apply_reset("reset");

        // Two distinct IDs back to back -> downstream IDs 0 and 1.
        drive_cycle(1, 8'h12, 1, 0, 0, 0, 1);
        drive_cycle(1, 8'h34, 1, 0, 0, 0, 1);
        check_val("r024_id1", 64'(mst_req_id), 64'd1);
        check_val("r024_busy", 64'(busy), 64'd1);

        // Same ID five times: four go out on slot 0, the fifth waits for a last beat.
        apply_reset("reset2");
        for (int i = 0; i < 5; i++) drive_cycle(1, 8'h12, 1, 0, 0, 0, 1);
        check_val("r025_stall", 64'(slv_req_ready), 64'd0);
        drive_cycle(1, 8'h12, 1, 1, 4'd0, 1, 1);
        drive_cycle(1, 8'h12, 1, 0, 0, 0, 1);
        check_val("r025_slot", 64'(mst_req_id), 64'd0);

        // Fill all sixteen slots; free slot 5; a new ID takes slot 5.
        apply_reset("reset3");
        for (int i = 0; i < NSLOT; i++) drive_cycle(1, 8'h80 + 8'(i), 1, 0, 0, 0, 1);
        drive_cycle(1, 8'hC0, 1, 0, 0, 0, 1);
        drive_cycle(1, 8'hC0, 1, 1, 4'd5, 1, 1);
        drive_cycle(1, 8'hC1, 1, 0, 0, 0, 1);
        check_val("r026_slot5", 64'(mst_req_id), 64'd5);

        // Slot 3 at count 1: same-ID request and last beat in one cycle.
        apply_reset("reset4");
        for (int i = 0; i < 4; i++) drive_cycle(1, 8'h30 + 8'(i), 1, 0, 0, 0, 1);
        drive_cycle(1, 8'h33, 1, 1, 4'd3, 1, 1);
        drive_cycle(0, 8'h00, 1, 1, 4'd3, 0, 1);
        check_val("r027_id", 64'(mst_req_id), 64'd3);
        check_val("r027_keep", 64'(slv_rsp_id), 64'h33);

        // Response on a free slot.
        apply_reset("reset5");
        drive_cycle(0, 8'h00, 1, 1, 4'd9, 1, 1);
        check_val("r028_id", 64'(slv_rsp_id), 64'd0);
`ifdef CULSANS_ID_REMAP_STAT_EN
        check_val("r028_cnt", 64'(unmapped_cnt), 64'd1);
        check_val("r028_flag", 64'(unmapped_rsp), 64'd1);
`endif

        // Reset with three slots busy, then a late response is unmapped.
        apply_reset("reset6");
        for (int i = 0; i < 3; i++) drive_cycle(1, 8'h50 + 8'(i), 1, 0, 0, 0, 1);
        apply_reset("r029");
        drive_cycle(0, 8'h00, 1, 1, 4'd1, 1, 1);

        // Randomized traffic; responses mostly target allocated slots.
        for (int n = 0; n < 1500; n++) begin
            q.delete();
            for (int i = 0; i < NSLOT; i++) if (m_cnt[i] > 0) q.push_back(i);
            if (q.size() > 0 && $urandom_range(0, 3) != 0)
                pid = 4'(q[$urandom_range(0, q.size() - 1)]);
            else
                pid = 4'($urandom_range(0, NSLOT - 1));
            drive_cycle($urandom_range(0, 3) != 0, 8'h40 + 8'($urandom_range(0, 23)),
                        $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, pid,
                        $urandom_range(0, 2) != 0, $urandom_range(0, 3) != 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/culsans_id_remap.md
CULSANS_ID_REMAP -- requirements
Module: culsans_id_remap

Interface
REQ-001 The block SHALL have parameter IN_ID_WIDTH, default 8: width of the upstream (slave-side) transaction ID.
REQ-002 The block SHALL have parameter OUT_ID_WIDTH, default 4: width of the downstream ID; the block has 2**OUT_ID_WIDTH remap slots.
REQ-003 The block SHALL have parameter MAX_TXN_PER_ID, default 4: maximum outstanding transactions per slot.
REQ-004 The block SHALL have parameters REQ_PLD_WIDTH and RSP_PLD_WIDTH, default 64: opaque request and response payload widths.
REQ-005 The block SHALL have these ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset
- slv_req_valid_i / slv_req_ready_o  in/out  1  upstream request handshake
- slv_req_id_i  in  IN_ID_WIDTH  upstream ID
- slv_req_pld_i  in  REQ_PLD_WIDTH  request payload
- mst_req_valid_o / mst_req_ready_i  out/in  1  downstream request handshake
- mst_req_id_o  out  OUT_ID_WIDTH  remapped ID
- mst_req_pld_o  out  REQ_PLD_WIDTH  payload
- mst_rsp_valid_i / mst_rsp_ready_o  in/out  1  downstream response handshake
- mst_rsp_id_i  in  OUT_ID_WIDTH  response ID
- mst_rsp_last_i  in  1  final beat
- mst_rsp_pld_i  in  RSP_PLD_WIDTH  payload
- slv_rsp_valid_o / slv_rsp_ready_i  out/in  1  upstream response handshake
- slv_rsp_id_o  out  IN_ID_WIDTH  restored ID
- slv_rsp_last_o  out  1  final beat
- slv_rsp_pld_o  out  RSP_PLD_WIDTH  payload
- busy_o  out  1  any slot allocated
REQ-006 There SHALL be one clock, clk_i; reset rst_ni SHALL be asynchronous and active-low.

Function
REQ-007 The request path SHALL use one output register: latency is 1 cycle, and a request is accepted when the register is empty or is being drained in the same cycle.
REQ-008 If slv_req_id_i matches an allocated slot whose count is below MAX_TXN_PER_ID, the request SHALL reuse that slot, preserving AXI same-ID ordering.
REQ-009 If the ID matches a slot at MAX_TXN_PER_ID, slv_req_ready_o SHALL be low.
REQ-010 If the ID is unmapped, the lowest-index free slot SHALL be allocated with count 1; if no slot is free, ready SHALL be low.
REQ-011 An allocation SHALL be visible to a following request in the next cycle; back-to-back same-ID requests SHALL map to the same slot.
REQ-012 The response path SHALL be combinational: slv_rsp_* mirrors mst_rsp_*, and slv_rsp_id_o is the table in_id of slot mst_rsp_id_i.
REQ-013 Each handshaked response beat with last=1 SHALL decrement its slot count; reaching 0 frees the slot.
REQ-014 Allocate/increment and decrement on the same slot in the same cycle SHALL leave the count unchanged and keep the slot allocated, including the count=1 case.
REQ-015 A free slot SHALL be reusable by a different ID in the cycle after it is freed.
REQ-016 busy_o SHALL be high while any slot count is non-zero or the output register is valid.
REQ-017 Counter width SHALL be $clog2(MAX_TXN_PER_ID+1) and SHALL never overflow or underflow.

Reset
REQ-018 On rst_ni low, all slots SHALL be free, counts 0, the output register invalid, and mst_req_valid_o, busy_o and stat outputs 0.
REQ-019 Reset mid-transaction SHALL discard all state; responses arriving after reset are unmapped.

Configuration
REQ-020 With CULSANS_ID_REMAP_STAT_EN defined, the block SHALL add unmapped_rsp_o (1 bit, sticky) and unmapped_cnt_o (16 bits, saturating); both count response last-beats hitting a free slot, and the beat is passed through with ID 0 and no decrement.
REQ-021 Without CULSANS_ID_REMAP_STAT_EN, those ports SHALL be absent and unmapped responses SHALL pass through with ID 0 and no table update.

Structure
REQ-022 Default ID widths (IdWidthSlave-derived) and the remap slot struct {in_id, count} SHALL live in culsans_pkg.
REQ-023 Slot table lookup, find-first-free and counters SHALL be one sub-module, culsans_id_remap_table; the top holds the request register and handshakes.

Verification
REQ-024 IDs 0x12, 0x34 in consecutive cycles -> mst IDs 0, 1; busy_o=1.
REQ-025 Five 0x12 requests with no responses -> four issued on slot 0, fifth stalls until a last beat on ID 0.
REQ-026 Sixteen distinct IDs fill all slots -> seventeenth stalls; last on slot 5 -> new ID takes slot 5 next cycle.
REQ-027 Slot 3 count 1; request for the same ID and last on slot 3 in the same cycle -> slot 3 is kept, count 1, mst ID 3.
REQ-028 Response on mst_rsp_id_i=9 with slot 9 free -> slv_rsp_id_o=0; with the macro, unmapped_cnt_o=1 and unmapped_rsp_o=1.
REQ-029 Assert rst_ni low with 3 slots busy -> next cycle busy_o=0 and all mst_req_valid_o=0.
